pipeline_stall_arbiter: RTL and testbench
=========================================

PIPELINE_STALL_ARBITER -- requirements
Module: pipeline_stall_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, lane and output data width.
REQ-002 Parameter: DEPTH, default 4, per-lane FIFO entries; power of two, at least 2.
REQ-003 Parameter: CNT_W, default 16, stall-cycle counter width.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  reset; synchronous, active-low.
REQ-006 Port: in_data_1  input  DATA_W  pipeline 1 result.
REQ-007 Port: in_valid_1  input  1  pipeline 1 result valid.
REQ-008 Port: in_data_2  input  DATA_W  pipeline 2 result.
REQ-009 Port: in_valid_2  input  1  pipeline 2 result valid.
REQ-010 Port: out_ready  input  1  shared sink can accept a word.
REQ-011 Port: out_data  output  DATA_W  arbitrated word.
REQ-012 Port: out_valid  output  1  out_data valid.
REQ-013 Port: out_src  output  1  source lane of out_data; 0 = pipeline 1, 1 = pipeline 2.
REQ-014 Port: global_stall  output  1  registered freeze request to both pipelines.
REQ-015 Port: stall_cycles  output  CNT_W  saturating count of cycles with global_stall high.

Function
REQ-016 A lane write occurs when in_valid_x is 1 and global_stall is 0; while global_stall is 1, inputs are ignored and upstream holds them.
REQ-017 Each lane SHALL buffer accepted words in its own FIFO of DEPTH entries, in order, with a count of 0..DEPTH.
REQ-018 Next global_stall = 1 when either lane's next count is at least DEPTH-1; otherwise 0.
REQ-019 Consequence: no FIFO overflows. Max count is DEPTH-1, or DEPTH after a simultaneous full-rate write.
REQ-020 The output register loads when it is empty (out_valid=0) or drains this cycle (out_valid and out_ready), and at least one FIFO is non-empty.
REQ-021 Arbitration is round-robin on last_grant: grant the lane other than last_grant if it is non-empty, else last_grant's lane if it is non-empty.
REQ-022 On a load: pop the granted FIFO; set out_data to its head, out_src to the lane, out_valid to 1; set last_grant to the lane.
REQ-023 On drain with both FIFOs empty, out_valid SHALL fall to 0 at the next edge.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_src and out_valid SHALL hold.
REQ-025 Latency: a word written to an empty lane at edge t, with the output register free, is presented with out_valid=1 after edge t+1.
REQ-026 Throughput: with out_ready held at 1, the block outputs one word per cycle while any FIFO holds data.
REQ-027 A same-cycle push and pop on one lane leaves its count unchanged.
REQ-028 Both lanes writing in the same cycle are both accepted.
REQ-029 stall_cycles increments each cycle global_stall is 1 and saturates at all-ones.

Reset
REQ-030 While reset=0 at a rising edge, the following state is cleared: FIFO counts and pointers, out_valid, out_data, out_src, global_stall and stall_cycles all go to 0; last_grant goes to 1.
REQ-031 Because last_grant resets to 1, lane 1 wins first when both lanes are pending.
REQ-032 Reset mid-operation discards all buffered words; nothing is output after the reset edge until a new write.

Structure
REQ-033 A shared package pipeline_arb_pkg holds the DATA_W, DEPTH and CNT_W defaults and the lane-id constants LANE_1=0 and LANE_2=1.
REQ-034 Each lane is one instance of sub-module lane_fifo (push, pop, data in/out, count, empty). Arbitration, output register and stall logic stay in pipeline_stall_arbiter.

Verification
REQ-035 Reset: drive reset=0 for 2 cycles with inputs active -> out_valid=0, global_stall=0, stall_cycles=0.
REQ-036 Single word, out_ready=1: in_data_1=0x11 for one cycle at edge t -> after edge t+1, out_valid=1, out_data=0x11, out_src=0; after edge t+2, out_valid=0.
REQ-037 Fairness, out_ready=1: both lanes valid every cycle with incrementing data (lane 1: 0x100.., lane 2: 0x200..) -> out_src alternates 0,1,0,1 starting at 0, and no word is lost or reordered per lane.
REQ-038 Backpressure, out_ready=0, DEPTH=4: both lanes valid -> global_stall rises after the 3rd accepted write, stall_cycles increments each stalled cycle. With out_ready=1 again, all 3 words per lane plus the one held in the output register drain in order and global_stall falls.
REQ-039 Hold: out_valid=1 with out_ready=0 for 5 cycles -> out_data and out_src remain constant.
REQ-040 Mid-run reset: reset=0 for one cycle while both FIFOs hold 2 words -> after that edge out_valid=0, and no stale word appears in the next 10 cycles with no input.

Source files
------------

// File: rtl/pipeline_arb_pkg.sv
// Shared defaults and lane identifiers for the pipeline stall arbiter.
package pipeline_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    LANE_1 = 1'b0,
    LANE_2 = 1'b1
  } lane_e;

  // The lane that is not `l`; round-robin prefers it after `l` was granted.
  function automatic lane_e other_lane(input lane_e l);
    return (l == LANE_1) ? LANE_2 : LANE_1;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane in-order FIFO with occupancy count (0..DEPTH); head is read combinationally.
module lane_fifo
  import pipeline_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: cleared by reset, which discards any buffered words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: written on push only, contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

endmodule

// File: rtl/pipeline_stall_arbiter.sv
// Merges two pipeline result streams into one sink with round-robin arbitration,
// per-lane buffering, a registered global stall and a saturating stall-cycle counter.
module pipeline_stall_arbiter
  import pipeline_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_valid_2,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_src,
  output logic              global_stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int FCNT_W = $clog2(DEPTH) + 1;
  // Stalling at DEPTH-1 leaves one slot of headroom for the write already in flight.
  localparam logic [FCNT_W-1:0] STALL_LVL = FCNT_W'(DEPTH - 1);

  function automatic logic [FCNT_W-1:0] next_count(input logic [FCNT_W-1:0] c,
                                                   input logic push,
                                                   input logic pop);
    return c + FCNT_W'(push) - FCNT_W'(pop);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              push_1, push_2, pop_1, pop_2;
  logic              empty_1, empty_2, load;
  logic [DATA_W-1:0] head_1, head_2;
  logic [FCNT_W-1:0] count_1, count_2;
  lane_e             rr_other, grant;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  lane_e             out_src_q, out_src_d;
  lane_e             last_grant_q, last_grant_d;
  logic              global_stall_q, global_stall_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  // Upstream holds its word while stalled, so a write is only taken when not stalled.
  assign push_1   = in_valid_1 & ~global_stall_q;
  assign push_2   = in_valid_2 & ~global_stall_q;
  assign rr_other = other_lane(last_grant_q);

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane_1 (
    .clk     (clk),
    .reset   (reset),
    .push    (push_1),
    .pop     (pop_1),
    .wr_data (in_data_1),
    .rd_data (head_1),
    .count   (count_1),
    .empty   (empty_1)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane_2 (
    .clk     (clk),
    .reset   (reset),
    .push    (push_2),
    .pop     (pop_2),
    .wr_data (in_data_2),
    .rd_data (head_2),
    .count   (count_2),
    .empty   (empty_2)
  );

  // Round-robin grant and the decision to load the output register from a lane.
  always_comb begin
    grant = last_grant_q;
    if ((rr_other == LANE_1 && !empty_1) || (rr_other == LANE_2 && !empty_2))
      grant = rr_other;
    load  = (!out_valid_q || out_ready) && (!empty_1 || !empty_2);
    pop_1 = load && (grant == LANE_1);
    pop_2 = load && (grant == LANE_2);
  end

  // Next state of the output register, grant history, stall flag and stall counter.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_src_d      = out_src_q;
    last_grant_d   = last_grant_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = (grant == LANE_1) ? head_1 : head_2;
      out_src_d    = grant;
      last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
    global_stall_d = (next_count(count_1, push_1, pop_1) >= STALL_LVL) ||
                     (next_count(count_2, push_2, pop_2) >= STALL_LVL);
    stall_cycles_d = global_stall_q ? sat_inc(stall_cycles_q) : stall_cycles_q;
  end

  // Register update; last_grant resets to lane 2 so lane 1 wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_src_q      <= LANE_1;
      last_grant_q   <= LANE_2;
      global_stall_q <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_src_q      <= out_src_d;
      last_grant_q   <= last_grant_d;
      global_stall_q <= global_stall_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_src      = out_src_q;
  assign global_stall = global_stall_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_arbiter.sv
// Directed bench for pipeline_stall_arbiter (DEPTH=4, narrow stall counter to reach saturation).
module tb_pipeline_stall_arbiter;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data_1, in_data_2;
  logic              in_valid_1, in_valid_2;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_src;
  logic              global_stall;
  logic [CNT_W-1:0]  stall_cycles;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_stall_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data_1    (in_data_1),
    .in_valid_1   (in_valid_1),
    .in_data_2    (in_data_2),
    .in_valid_2   (in_valid_2),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_src      (out_src),
    .global_stall (global_stall),
    .stall_cycles (stall_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    in_data_1  = '0;
    in_data_2  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    out_ready = 1'b1;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid_1 = 1'b1; in_data_1 = 32'hAA;
    in_valid_2 = 1'b1; in_data_2 = 32'hBB;
    step();
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    vectors++; if (global_stall !== 1'b0) begin miscompares++; $display("FAIL reset_global_stall: got %b, expected 0", global_stall); end
    vectors++; if (stall_cycles !== 4'd0) begin miscompares++; $display("FAIL reset_stall_cycles: got %0d, expected 0", stall_cycles); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
    vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL reset_out_src: got %b, expected 0", out_src); end
    idle_inputs();
    reset = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_ghost: got %b, expected 0", out_valid); end
  endtask

  task automatic test_single_word();
    apply_reset();
    in_valid_1 = 1'b1; in_data_1 = 32'h11;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single1_early: got %b, expected 0", out_valid); end
    idle_inputs();
    step();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single1_valid: got %b, expected 1", out_valid); end
    vectors++; if (out_data !== 32'h11) begin miscompares++; $display("FAIL single1_data: got %h, expected 11", out_data); end
    vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL single1_src: got %b, expected 0", out_src); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single1_fall: got %b, expected 0", out_valid); end
    in_valid_2 = 1'b1; in_data_2 = 32'h22;
    step();
    idle_inputs();
    step();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single2_valid: got %b, expected 1", out_valid); end
    vectors++; if (out_data !== 32'h22) begin miscompares++; $display("FAIL single2_data: got %h, expected 22", out_data); end
    vectors++; if (out_src !== 1'b1) begin miscompares++; $display("FAIL single2_src: got %b, expected 1", out_src); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single2_fall: got %b, expected 0", out_valid); end
  endtask

  // Both lanes push every cycle; words must alternate lanes starting with lane 1,
  // arrive in per-lane order, and come out one per cycle whenever any word is buffered.
  task automatic test_fairness();
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] q2[$];
    logic [DATA_W-1:0] exp_d;
    int   n1, n2, pending, avail_before, acc_now;
    logic exp_src, exp_v;
    apply_reset();
    n1 = 0; n2 = 0; pending = 0; exp_src = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 12) begin
        in_valid_1 = 1'b1; in_data_1 = 32'h100 + n1;
        in_valid_2 = 1'b1; in_data_2 = 32'h200 + n2;
      end else begin
        idle_inputs();
      end
      acc_now = 0;
      if (in_valid_1 && !global_stall) begin q1.push_back(in_data_1); n1++; acc_now++; end
      if (in_valid_2 && !global_stall) begin q2.push_back(in_data_2); n2++; acc_now++; end
      avail_before = pending;
      step();
      exp_v = (avail_before > 0);
      vectors++; if (out_valid !== exp_v) begin miscompares++; $display("FAIL fair_valid cycle %0d: got %b, expected %b", c, out_valid, exp_v); end
      if (out_valid === 1'b1) begin
        vectors++; if (out_src !== exp_src) begin miscompares++; $display("FAIL fair_src cycle %0d: got %b, expected %b", c, out_src, exp_src); end
        if (exp_src == 1'b0) exp_d = (q1.size() > 0) ? q1.pop_front() : 32'hDEAD_0001;
        else                 exp_d = (q2.size() > 0) ? q2.pop_front() : 32'hDEAD_0002;
        vectors++; if (out_data !== exp_d) begin miscompares++; $display("FAIL fair_data cycle %0d: got %h, expected %h", c, out_data, exp_d); end
        exp_src = ~exp_src;
        pending--;
      end
      pending += acc_now;
    end
    vectors++; if (q1.size() != 0 || q2.size() != 0) begin miscompares++; $display("FAIL fair_lost: got %0d/%0d words left, expected 0/0", q1.size(), q2.size()); end
    vectors++; if (n1 < 3) begin miscompares++; $display("FAIL fair_accepted: got %0d lane-1 writes, expected at least 3", n1); end
  endtask

  // Sink blocked: stall rises after the third write, holds the output word,
  // counter saturates at 15, then everything drains in round-robin order.
  task automatic test_backpressure_hold();
    logic [DATA_W-1:0] exp_d [5];
    logic              exp_s [5];
    logic [CNT_W-1:0]  exp_cnt;
    apply_reset();
    out_ready = 1'b0;
    in_valid_1 = 1'b1; in_data_1 = 32'h100;
    in_valid_2 = 1'b1; in_data_2 = 32'h200;
    step();
    vectors++; if (global_stall !== 1'b0) begin miscompares++; $display("FAIL bp_stall_w1: got %b, expected 0", global_stall); end
    in_data_1 = 32'h101; in_data_2 = 32'h201;
    step();
    vectors++; if (global_stall !== 1'b0) begin miscompares++; $display("FAIL bp_stall_w2: got %b, expected 0", global_stall); end
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h100) begin miscompares++; $display("FAIL bp_first_out: got %b/%h, expected 1/100", out_valid, out_data); end
    in_data_1 = 32'h102; in_data_2 = 32'h202;
    step();
    vectors++; if (global_stall !== 1'b1) begin miscompares++; $display("FAIL bp_stall_w3: got %b, expected 1", global_stall); end
    vectors++; if (stall_cycles !== 4'd0) begin miscompares++; $display("FAIL bp_cnt_w3: got %0d, expected 0", stall_cycles); end
    in_data_1 = 32'h1FF; in_data_2 = 32'h2FF;
    for (int s = 1; s <= 20; s++) begin
      step();
      exp_cnt = (s > 15) ? 4'd15 : 4'(s);
      vectors++; if (global_stall !== 1'b1) begin miscompares++; $display("FAIL bp_stall_hold s=%0d: got %b, expected 1", s, global_stall); end
      vectors++; if (stall_cycles !== exp_cnt) begin miscompares++; $display("FAIL bp_cnt s=%0d: got %0d, expected %0d", s, stall_cycles, exp_cnt); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid s=%0d: got %b, expected 1", s, out_valid); end
      vectors++; if (out_data !== 32'h100) begin miscompares++; $display("FAIL hold_data s=%0d: got %h, expected 100", s, out_data); end
      vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL hold_src s=%0d: got %b, expected 0", s, out_src); end
    end
    exp_d[0] = 32'h200; exp_s[0] = 1'b1;
    exp_d[1] = 32'h101; exp_s[1] = 1'b0;
    exp_d[2] = 32'h201; exp_s[2] = 1'b1;
    exp_d[3] = 32'h102; exp_s[3] = 1'b0;
    exp_d[4] = 32'h202; exp_s[4] = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_src !== exp_s[k]) begin
        miscompares++;
        $display("FAIL drain_%0d: got %b/%h/%b, expected 1/%h/%b", k, out_valid, out_data, out_src, exp_d[k], exp_s[k]);
      end
      vectors++; if (global_stall !== 1'b0) begin miscompares++; $display("FAIL drain_stall_%0d: got %b, expected 0", k, global_stall); end
    end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got %b, expected 0", out_valid); end
    vectors++; if (stall_cycles !== 4'd15) begin miscompares++; $display("FAIL drain_cnt: got %0d, expected 15", stall_cycles); end
  endtask

  task automatic test_midrun_reset();
    apply_reset();
    out_ready = 1'b0;
    in_valid_1 = 1'b1; in_data_1 = 32'h300;
    in_valid_2 = 1'b1; in_data_2 = 32'h400;
    step();
    in_data_1 = 32'h301; in_data_2 = 32'h401;
    step();
    in_valid_2 = 1'b0; in_data_1 = 32'h302;
    step();
    vectors++; if (out_valid !== 1'b1 || global_stall !== 1'b0) begin miscompares++; $display("FAIL mid_preload: got %b/%b, expected 1/0", out_valid, global_stall); end
    idle_inputs();
    out_ready = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b, expected 0", out_valid); end
    vectors++; if (global_stall !== 1'b0 || stall_cycles !== 4'd0) begin miscompares++; $display("FAIL mid_reset_stall: got %b/%0d, expected 0/0", global_stall, stall_cycles); end
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale cycle %0d: got %b/%h, expected 0", c, out_valid, out_data); end
    end
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_single_word();
    test_fairness();
    test_backpressure_hold();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
